// File: rtl/time_keeper.sv
// time_keeper: live calendar/time counters advanced once per second from a
// clk-derived prescaler, with a one-cycle load path from the setting controller.
// Optional feature: define LOAD_CLAMP_EN to clamp loaded values into their legal
// ranges; without it loaded values are held as-is and wrap at the next advance.
module time_keeper #(
   parameter int TICK_DIV = 100000000,
   parameter int PRESC_W  = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       set_done,
   input  logic [5:0] in_sec,
   input  logic [5:0] in_min,
   input  logic [4:0] in_hour,
   input  logic [4:0] in_day,
   input  logic [3:0] in_month,
   output logic [5:0] cur_sec,
   output logic [5:0] cur_min,
   output logic [4:0] cur_hour,
   output logic [4:0] cur_day,
   output logic [3:0] cur_month,
   output logic       sec_tick,
   output logic       day_roll,
   output logic       load_ack
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   // Days in a month; anything outside 1..12 is treated like February.
   function automatic logic [4:0] days_in_month(input logic [3:0] month);
      logic [4:0] dim;
      case (month)
         4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: dim = 5'd31;
         4'd4, 4'd6, 4'd9, 4'd11:                    dim = 5'd30;
         default:                                    dim = 5'd28;
      endcase
      return dim;
   endfunction

`ifdef LOAD_CLAMP_EN
   function automatic logic [5:0] clamp_59(input logic [5:0] v);
      return (v > 6'd59) ? 6'd59 : v;
   endfunction

   function automatic logic [4:0] clamp_hour(input logic [4:0] v);
      return (v > 5'd23) ? 5'd23 : v;
   endfunction

   function automatic logic [3:0] clamp_month(input logic [3:0] v);
      logic [3:0] r;
      if (v == 4'd0)       r = 4'd1;
      else if (v > 4'd12)  r = 4'd12;
      else                 r = v;
      return r;
   endfunction

   // Day limit depends on the already-clamped month.
   function automatic logic [4:0] clamp_day(input logic [4:0] v, input logic [3:0] month);
      logic [4:0] dim;
      logic [4:0] r;
      dim = days_in_month(month);
      if (v == 5'd0)      r = 5'd1;
      else if (v > dim)   r = dim;
      else                r = v;
      return r;
   endfunction
`endif

   logic [5:0] ld_sec, ld_min;
   logic [4:0] ld_hour, ld_day;
   logic [3:0] ld_month;

`ifdef LOAD_CLAMP_EN
   assign ld_sec   = clamp_59(in_sec);
   assign ld_min   = clamp_59(in_min);
   assign ld_hour  = clamp_hour(in_hour);
   assign ld_month = clamp_month(in_month);
   assign ld_day   = clamp_day(in_day, ld_month);
`else
   assign ld_sec   = in_sec;
   assign ld_min   = in_min;
   assign ld_hour  = in_hour;
   assign ld_month = in_month;
   assign ld_day   = in_day;
`endif

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [5:0]         sec_q, sec_d;
   logic [5:0]         min_q, min_d;
   logic [4:0]         hour_q, hour_d;
   logic [4:0]         day_q, day_d;
   logic [3:0]         month_q, month_d;
   logic               sec_tick_q, sec_tick_d;
   logic               day_roll_q, day_roll_d;
   logic               load_ack_q, load_ack_d;

   // Next-state: a load wins over an advance; otherwise run the prescaler and carry chain.
   always_comb begin
      presc_d    = presc_q;
      sec_d      = sec_q;
      min_d      = min_q;
      hour_d     = hour_q;
      day_d      = day_q;
      month_d    = month_q;
      sec_tick_d = 1'b0;
      day_roll_d = 1'b0;
      load_ack_d = 1'b0;

      if (set_done) begin
         presc_d    = '0;
         sec_d      = ld_sec;
         min_d      = ld_min;
         hour_d     = ld_hour;
         day_d      = ld_day;
         month_d    = ld_month;
         load_ack_d = 1'b1;
      end else if (presc_q == PRESC_LAST) begin
         presc_d    = '0;
         sec_tick_d = 1'b1;
         // >= comparisons let out-of-range loaded fields wrap to their minimum.
         if (sec_q >= 6'd59) begin
            sec_d = 6'd0;
            if (min_q >= 6'd59) begin
               min_d = 6'd0;
               if (hour_q >= 5'd23) begin
                  hour_d     = 5'd0;
                  day_roll_d = 1'b1;
                  if (day_q >= days_in_month(month_q)) begin
                     day_d   = 5'd1;
                     month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
                  end else begin
                     day_d = day_q + 5'd1;
                  end
               end else begin
                  hour_d = hour_q + 5'd1;
               end
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end else begin
         presc_d = presc_q + PRESC_W'(1);
      end
   end

   // State registers; asynchronous reset returns to 01-01 00:00:00.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q    <= '0;
         sec_q      <= 6'd0;
         min_q      <= 6'd0;
         hour_q     <= 5'd0;
         day_q      <= 5'd1;
         month_q    <= 4'd1;
         sec_tick_q <= 1'b0;
         day_roll_q <= 1'b0;
         load_ack_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hour_q     <= hour_d;
         day_q      <= day_d;
         month_q    <= month_d;
         sec_tick_q <= sec_tick_d;
         day_roll_q <= day_roll_d;
         load_ack_q <= load_ack_d;
      end
   end

   assign cur_sec   = sec_q;
   assign cur_min   = min_q;
   assign cur_hour  = hour_q;
   assign cur_day   = day_q;
   assign cur_month = month_q;
   assign sec_tick  = sec_tick_q;
   assign day_roll  = day_roll_q;
   assign load_ack  = load_ack_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: randomized and directed bench for time_keeper (TICK_DIV=4),
// compared against a calendar reference model kept in the bench.
module tb_time_keeper;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       set_done;
   logic [5:0] in_sec, in_min;
   logic [4:0] in_hour, in_day;
   logic [3:0] in_month;
   logic [5:0] cur_sec, cur_min;
   logic [4:0] cur_hour, cur_day;
   logic [3:0] cur_month;
   logic       sec_tick, day_roll, load_ack;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int m_sec, m_min, m_hour, m_day, m_mon, m_presc;
   bit m_tick, m_roll, m_ack;
   int dim_tab[13] = '{28, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

   time_keeper #(.TICK_DIV(TD), .PRESC_W(3)) dut (
      .clk(clk), .rst(rst), .set_done(set_done),
      .in_sec(in_sec), .in_min(in_min), .in_hour(in_hour),
      .in_day(in_day), .in_month(in_month),
      .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
      .cur_day(cur_day), .cur_month(cur_month),
      .sec_tick(sec_tick), .day_roll(day_roll), .load_ack(load_ack)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int dim_of(input int mon);
      if (mon >= 1 && mon <= 12) return dim_tab[mon];
      return 28;
   endfunction

   function automatic logic [31:0] mk(input int mon, input int day, input int hour,
                                      input int mn, input int sec,
                                      input bit t, input bit r, input bit a);
      return {3'b000, mon[3:0], day[4:0], hour[4:0], mn[5:0], sec[5:0], t, r, a};
   endfunction

   function automatic logic [31:0] dut_vec();
      return {3'b000, cur_month, cur_day, cur_hour, cur_min, cur_sec, sec_tick, day_roll, load_ack};
   endfunction

   function automatic logic [31:0] model_vec();
      return mk(m_mon, m_day, m_hour, m_min, m_sec, m_tick, m_roll, m_ack);
   endfunction

   function automatic void model_reset();
      m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_presc = 0;
      m_tick = 0; m_roll = 0; m_ack = 0;
   endfunction

   // One second of calendar time; fields at or past their maximum wrap.
   function automatic void model_advance();
      bit c;
      c = (m_sec >= 59);
      m_sec = c ? 0 : m_sec + 1;
      if (!c) return;
      c = (m_min >= 59);
      m_min = c ? 0 : m_min + 1;
      if (!c) return;
      c = (m_hour >= 23);
      m_hour = c ? 0 : m_hour + 1;
      if (!c) return;
      m_roll = 1;
      if (m_day >= dim_of(m_mon)) begin
         m_day = 1;
         m_mon = (m_mon >= 12) ? 1 : m_mon + 1;
      end else begin
         m_day = m_day + 1;
      end
   endfunction

   function automatic void model_step();
      int ls, lm, lh, ld, lmo;
      if (!rst) begin
         model_reset();
         return;
      end
      m_tick = 0; m_roll = 0; m_ack = 0;
      if (set_done) begin
         ls = int'(in_sec); lm = int'(in_min); lh = int'(in_hour);
         ld = int'(in_day); lmo = int'(in_month);
`ifdef LOAD_CLAMP_EN
         if (ls > 59) ls = 59;
         if (lm > 59) lm = 59;
         if (lh > 23) lh = 23;
         if (lmo < 1) lmo = 1;
         if (lmo > 12) lmo = 12;
         if (ld < 1) ld = 1;
         if (ld > dim_of(lmo)) ld = dim_of(lmo);
`endif
         m_sec = ls; m_min = lm; m_hour = lh; m_day = ld; m_mon = lmo;
         m_presc = 0;
         m_ack = 1;
      end else if (m_presc == TD - 1) begin
         m_presc = 0;
         m_tick = 1;
         model_advance();
      end else begin
         m_presc = m_presc + 1;
      end
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
      model_step();
      check_val("cyc", dut_vec(), model_vec());
   endtask

   task automatic load(input int mon, input int day, input int hour, input int mn, input int sec);
      in_month = 4'(mon); in_day = 5'(day); in_hour = 5'(hour);
      in_min = 6'(mn); in_sec = 6'(sec);
      set_done = 1'b1;
      cycle();
      set_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      rst = 1'b0; set_done = 1'b0;
      in_sec = '0; in_min = '0; in_hour = '0; in_day = '0; in_month = '0;
      model_reset();

      // Reset held for 3 cycles, then first tick after 4 cycles
      repeat (3) cycle();
      check_val("rst_state", dut_vec(), mk(1, 1, 0, 0, 0, 0, 0, 0));
      rst = 1'b1;
      repeat (4) cycle();
      check_val("first_tick", dut_vec(), mk(1, 1, 0, 0, 1, 1, 0, 0));

      // Load then count through end of February
      load(2, 28, 23, 59, 58);
      check_val("load_0228", dut_vec(), mk(2, 28, 23, 59, 58, 0, 0, 1));
      repeat (4) cycle();
      check_val("sec59", dut_vec(), mk(2, 28, 23, 59, 59, 1, 0, 0));
      repeat (4) cycle();
      check_val("feb_roll", dut_vec(), mk(3, 1, 0, 0, 0, 1, 1, 0));

      // Year wrap and 30-day month
      load(12, 31, 23, 59, 59);
      repeat (4) cycle();
      check_val("year_wrap", dut_vec(), mk(1, 1, 0, 0, 0, 1, 1, 0));
      load(4, 30, 23, 59, 59);
      repeat (4) cycle();
      check_val("apr_roll", dut_vec(), mk(5, 1, 0, 0, 0, 1, 1, 0));

      // Load colliding with an advance
      for (int i = 0; i < 8 && m_presc != TD - 1; i++) cycle();
      load(6, 15, 10, 20, 30);
      check_val("collide", dut_vec(), mk(6, 15, 10, 20, 30, 0, 0, 1));
      waited = 0;
      while (sec_tick !== 1'b1 && waited < 10) begin
         cycle();
         waited++;
      end
      check_val("tick_gap", 32'(waited), 32'd4);

      // Back-to-back loads keep load_ack high and the prescaler at 0
      in_month = 4'd8; in_day = 5'd9; in_hour = 5'd1; in_min = 6'd2; in_sec = 6'd3;
      set_done = 1'b1;
      cycle();
      in_sec = 6'd4;
      cycle();
      in_sec = 6'd5;
      cycle();
      set_done = 1'b0;
      check_val("b2b_load", dut_vec(), mk(8, 9, 1, 2, 5, 0, 0, 1));
      repeat (4) cycle();
      check_val("b2b_tick", dut_vec(), mk(8, 9, 1, 2, 6, 1, 0, 0));

      // Asynchronous reset between edges
      load(7, 4, 12, 34, 56);
      repeat (2) cycle();
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      check_val("async_rst", dut_vec(), mk(1, 1, 0, 0, 0, 0, 0, 0));
      cycle();
      rst = 1'b1;
      repeat (4) cycle();
      check_val("resume", dut_vec(), mk(1, 1, 0, 0, 1, 1, 0, 0));

`ifdef LOAD_CLAMP_EN
      load(0, 31, 30, 63, 60);
      check_val("clamp_all", dut_vec(), mk(1, 31, 23, 59, 59, 0, 0, 1));
      load(2, 30, 0, 0, 0);
      check_val("clamp_feb", dut_vec(), mk(2, 28, 0, 0, 0, 0, 0, 1));
`else
      load(5, 10, 30, 59, 59);
      check_val("oor_hold", dut_vec(), mk(5, 10, 30, 59, 59, 0, 0, 1));
      repeat (4) cycle();
      check_val("oor_wrap", dut_vec(), mk(5, 11, 0, 0, 0, 1, 1, 0));
`endif

      // Randomized loads biased toward rollover boundaries
      for (int i = 0; i < 3000; i++) begin
         set_done = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) begin
            in_sec = 6'($urandom_range(0, 63));
            in_min = 6'($urandom_range(0, 63));
            in_hour = 5'($urandom_range(0, 31));
            in_day = 5'($urandom_range(0, 31));
            in_month = 4'($urandom_range(0, 15));
         end else begin
            in_sec = 6'($urandom_range(55, 59));
            in_min = 6'($urandom_range(58, 59));
            in_hour = 5'($urandom_range(22, 23));
            in_day = 5'($urandom_range(27, 31));
            in_month = 4'($urandom_range(1, 12));
         end
         cycle();
      end
      set_done = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Consumer end of the time-setting interface: receives the one-cycle `set_done` pulse and the five set values from the setting-mode controller.
- Loads those values into live calendar/time counters, then advances them once per second from a clk-derived prescaler.
- Drives `cur_*` to the display/alarm logic and emits per-second and day-rollover strobes.

Parameters:
- TICK_DIV, default 100000000: clk cycles per second (prescaler modulus). Legal range ≥2.
- PRESC_W, default 27: prescaler counter width. Must satisfy 2^PRESC_W ≥ TICK_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- set_done  in  1  one-cycle load strobe from setting controller
- in_sec  in  6  value to load, 0..59
- in_min  in  6  value to load, 0..59
- in_hour  in  5  value to load, 0..23
- in_day  in  5  value to load, 1..31
- in_month  in  4  value to load, 1..12
- cur_sec  out  6  live seconds
- cur_min  out  6  live minutes
- cur_hour  out  5  live hours
- cur_day  out  5  live day of month
- cur_month  out  4  live month
- sec_tick  out  1  one-cycle pulse on each second advance
- day_roll  out  1  one-cycle pulse when 23:59:59 advances to 00:00:00
- load_ack  out  1  one-cycle pulse confirming a load

Behaviour:
- Reset (rst=0, async): cur_sec=0, cur_min=0, cur_hour=0, cur_day=1, cur_month=1. Prescaler=0. sec_tick=0, day_roll=0, load_ack=0. All outputs are registered.
- Prescaler: counts 0..TICK_DIV-1. In the cycle it equals TICK_DIV-1 it wraps to 0 and an internal advance occurs.
- Advance, on the same clock edge:
  - sec_tick=1 for one cycle.
  - Seconds: cur_sec+1; 59 wraps to 0 and carries to minutes.
  - Minutes: 59 wraps to 0 and carries to hours.
  - Hours: 23 wraps to 0, carries to days, and day_roll=1 for one cycle.
- Day carry: dim = days in cur_month (31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; 28 for 2 and for any other value).
  - If cur_day ≥ dim: cur_day=1 and carry to month.
  - Otherwise cur_day+1.
- Month carry: cur_month ≥ 12 → 1; otherwise cur_month+1.
- Load: set_done=1 has priority over an advance in the same cycle.
  - Next edge: cur_* ← in_*, prescaler ← 0, load_ack=1 for one cycle.
  - sec_tick and day_roll stay 0 that cycle.
  - The first advance after a load occurs exactly TICK_DIV cycles later.
- Back-to-back set_done on consecutive cycles: each cycle reloads. load_ack stays high for every cycle of the run. Prescaler stays 0.
- set_done is sampled only at clk edges; a pulse wider than one cycle is treated as repeated loads.
- Reset mid-count or mid-load: immediate return to reset values; any pending load is discarded.
- Out-of-range loaded values (without the optional feature) are held as-is. At the next advance the wrap comparisons use ≥, so any field at or above its maximum wraps to its minimum and carries.

Optional Feature:
- Macro LOAD_CLAMP_EN.
- When defined, values are clamped at load:
  - in_sec, in_min: >59 → 59.
  - in_hour: >23 → 23.
  - in_month: 0 → 1, >12 → 12.
  - in_day: 0 → 1, > dim of the clamped month → dim.
- When not defined, in_* are loaded unmodified and the ≥-wrap rule above applies.

Test Plan (TICK_DIV=4 unless stated):
- Reset: hold rst=0 for 3 cycles, release → cur=01-01 00:00:00. After 4 cycles, first sec_tick pulse and cur_sec=1.
- Load then count: set_done with 02-28 23:59:58 → load_ack next edge, cur equals loaded values. After 4 cycles cur_sec=59. After 8 cycles cur=03-01 00:00:00 with sec_tick=1 and day_roll=1 on the same cycle.
- Year wrap: load 12-31 23:59:59 → after 4 cycles cur=01-01 00:00:00 and day_roll=1. Load 04-30 23:59:59 → 05-01 00:00:00.
- Load/advance collision: assert set_done in the cycle where the prescaler equals 3, loading 06-15 10:20:30 → no sec_tick that cycle, cur=06-15 10:20:30, next sec_tick exactly 4 cycles after load_ack.
- Async reset mid-run: drop rst between clk edges while cur=07-04 12:34:56 → outputs take reset values before the next edge. Release → counting resumes from 01-01 00:00:00.
- LOAD_CLAMP_EN defined: load month=0, day=31, hour=30, min=63, sec=60 → cur=01-31 23:59:59. Load month=2, day=30 → cur_day=28. Without the macro, hour=30 loads as 30 and wraps to 0 with day carry at the next advance after sec and min reach 59.
